// File: rtl/ibex_rvfi_pkg.sv
// Shared types for the RVFI retirement producer: buffered entry layout and order width.
package ibex_rvfi_pkg;

    localparam int RvfiOrderW = 64;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic        is_load;
        logic        complete;
    } rvfi_entry_t;

    // A bus error turns the load into a trap with no architectural register write.
    function automatic rvfi_entry_t complete_load(rvfi_entry_t e, logic [31:0] rdata, logic err);
        rvfi_entry_t r;
        r           = e;
        r.complete  = 1'b1;
        r.rd_wdata  = rdata;
        r.mem_rdata = rdata;
        if (err) begin
            r.trap     = 1'b1;
            r.rd_addr  = '0;
            r.rd_wdata = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/ibex_rvfi_fifo.sv
// In-order retire buffer; the one outstanding load entry is completed in place by index.
module ibex_rvfi_fifo
    import ibex_rvfi_pkg::*;
#(
    parameter  int Depth = 2,
    localparam int AW    = $clog2(Depth)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  rvfi_entry_t       push_entry,
    input  logic              pop,
    input  logic              cmpl,
    input  logic [AW-1:0]     cmpl_idx,
    input  logic [31:0]       cmpl_rdata,
    input  logic              cmpl_err,
    output rvfi_entry_t       head,
    output logic              full,
    output logic              empty,
    output logic [AW-1:0]     wr_idx
);

    localparam logic [AW:0] PtrOne = 1;

    rvfi_entry_t mem [Depth];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_idx  = wr_ptr[AW-1:0];
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_idx] <= push_entry;
                wr_ptr      <= wr_ptr + PtrOne;
            end
            if (cmpl) begin
                mem[cmpl_idx] <= complete_load(mem[cmpl_idx], cmpl_rdata, cmpl_err);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
        end
    end

endmodule

// File: rtl/ibex_rvfi_gen.sv
// RVFI producer: buffers retirements until load data returns, then emits one registered
// rvfi_valid pulse per instruction in program order with an incrementing rvfi_order.
module ibex_rvfi_gen
    import ibex_rvfi_pkg::*;
#(
    parameter int         FifoDepth = 2,
    parameter logic [1:0] HartIxl   = 2'b01
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_done_i,
    output logic                  instr_ready_o,
    input  logic [31:0]           insn_i,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           pc_next_i,
    input  logic [4:0]            rs1_addr_i,
    input  logic [4:0]            rs2_addr_i,
    input  logic [31:0]           rs1_rdata_i,
    input  logic [31:0]           rs2_rdata_i,
    input  logic [4:0]            rd_addr_i,
    input  logic [31:0]           rd_wdata_i,
    input  logic                  is_load_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [3:0]            mem_rmask_i,
    input  logic [3:0]            mem_wmask_i,
    input  logic [31:0]           mem_wdata_i,
    input  logic                  trap_i,
    input  logic                  halt_i,
    input  logic [1:0]            priv_mode_i,
    input  logic                  irq_taken_i,
    input  logic                  load_resp_valid_i,
    input  logic [31:0]           load_rdata_i,
    input  logic                  load_err_i,
    output logic                  rvfi_valid,
    output logic [RvfiOrderW-1:0] rvfi_order,
    output logic [31:0]           rvfi_insn,
    output logic                  rvfi_trap,
    output logic                  rvfi_halt,
    output logic                  rvfi_intr,
    output logic [1:0]            rvfi_mode,
    output logic [1:0]            rvfi_ixl,
    output logic [4:0]            rvfi_rs1_addr,
    output logic [4:0]            rvfi_rs2_addr,
    output logic [4:0]            rvfi_rs3_addr,
    output logic [31:0]           rvfi_rs1_rdata,
    output logic [31:0]           rvfi_rs2_rdata,
    output logic [31:0]           rvfi_rs3_rdata,
    output logic [4:0]            rvfi_rd_addr,
    output logic [31:0]           rvfi_rd_wdata,
    output logic [31:0]           rvfi_pc_rdata,
    output logic [31:0]           rvfi_pc_wdata,
    output logic [31:0]           rvfi_mem_addr,
    output logic [3:0]            rvfi_mem_rmask,
    output logic [3:0]            rvfi_mem_wmask,
    output logic [31:0]           rvfi_mem_rdata,
    output logic [31:0]           rvfi_mem_wdata,
    output logic                  proto_err_o
);

    localparam int IdxW = $clog2(FifoDepth);
    localparam logic [RvfiOrderW-1:0] OrderOne = 1;

    rvfi_entry_t           new_entry;
    rvfi_entry_t           head;
    logic                  full;
    logic                  empty;
    logic [IdxW-1:0]       wr_idx;
    logic [IdxW-1:0]       pend_idx;
    logic                  pend_vld;
    logic                  intr_pend;
    logic [RvfiOrderW-1:0] order_cnt;

    logic done_ok;
    logic err_done;
    logic err_load;
    logic err_resp;
    logic enq;
    logic resp_at_enq;
    logic resp_pend;
    logic deq;

    assign instr_ready_o = !full;

    // Violating events are dropped; only the sticky flag records them.
    assign done_ok     = instr_done_i && instr_ready_o;
    assign err_done    = instr_done_i && !instr_ready_o;
    assign err_load    = done_ok && is_load_i && pend_vld;
    assign enq         = done_ok && !err_load;
    assign resp_at_enq = enq && is_load_i && load_resp_valid_i;
    assign resp_pend   = load_resp_valid_i && pend_vld;
    assign err_resp    = load_resp_valid_i && !pend_vld && !resp_at_enq;
    assign deq         = !empty && head.complete;

    always_comb begin
        new_entry           = '0;
        new_entry.insn      = insn_i;
        new_entry.pc_rdata  = pc_i;
        new_entry.pc_wdata  = pc_next_i;
        new_entry.rs1_addr  = rs1_addr_i;
        new_entry.rs2_addr  = rs2_addr_i;
        new_entry.rs1_rdata = rs1_rdata_i;
        new_entry.rs2_rdata = rs2_rdata_i;
        new_entry.rd_addr   = rd_addr_i;
        new_entry.rd_wdata  = is_load_i ? 32'h0 : rd_wdata_i;
        new_entry.mem_addr  = mem_addr_i;
        new_entry.mem_rmask = mem_rmask_i;
        new_entry.mem_wmask = mem_wmask_i;
        new_entry.mem_wdata = mem_wdata_i;
        new_entry.trap      = trap_i;
        new_entry.halt      = halt_i;
        new_entry.intr      = intr_pend || irq_taken_i;
        new_entry.mode      = priv_mode_i;
        new_entry.is_load   = is_load_i;
        new_entry.complete  = !is_load_i;
        if (resp_at_enq) begin
            new_entry = complete_load(new_entry, load_rdata_i, load_err_i);
        end
    end

    ibex_rvfi_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (enq),
        .push_entry (new_entry),
        .pop        (deq),
        .cmpl       (resp_pend),
        .cmpl_idx   (pend_idx),
        .cmpl_rdata (load_rdata_i),
        .cmpl_err   (load_err_i),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .wr_idx     (wr_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_vld    <= 1'b0;
            pend_idx    <= '0;
            intr_pend   <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            if (resp_pend) begin
                pend_vld <= 1'b0;
            end else if (enq && is_load_i && !load_resp_valid_i) begin
                pend_vld <= 1'b1;
                pend_idx <= wr_idx;
            end
            if (enq) begin
                intr_pend <= 1'b0;
            end else if (irq_taken_i) begin
                intr_pend <= 1'b1;
            end
            if (err_done || err_load || err_resp) begin
                proto_err_o <= 1'b1;
            end
        end
    end

    assign rvfi_ixl       = HartIxl;
    assign rvfi_rs3_addr  = '0;
    assign rvfi_rs3_rdata = '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvfi_valid     <= 1'b0;
            rvfi_order     <= '0;
            order_cnt      <= '0;
            rvfi_insn      <= '0;
            rvfi_trap      <= 1'b0;
            rvfi_halt      <= 1'b0;
            rvfi_intr      <= 1'b0;
            rvfi_mode      <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else begin
            rvfi_valid <= deq;
            if (deq) begin
                rvfi_order     <= order_cnt;
                order_cnt      <= order_cnt + OrderOne;
                rvfi_insn      <= head.insn;
                rvfi_trap      <= head.trap;
                rvfi_halt      <= head.halt;
                rvfi_intr      <= head.intr;
                rvfi_mode      <= head.mode;
                rvfi_rs1_addr  <= head.rs1_addr;
                rvfi_rs2_addr  <= head.rs2_addr;
                rvfi_rs1_rdata <= head.rs1_rdata;
                rvfi_rs2_rdata <= head.rs2_rdata;
                rvfi_rd_addr   <= head.rd_addr;
                // x0 never reports a written value, even for loads targeting it.
                rvfi_rd_wdata  <= (head.rd_addr == 5'd0) ? 32'h0 : head.rd_wdata;
                rvfi_pc_rdata  <= head.pc_rdata;
                rvfi_pc_wdata  <= head.pc_wdata;
                rvfi_mem_addr  <= head.mem_addr;
                rvfi_mem_rmask <= head.mem_rmask;
                rvfi_mem_wmask <= head.mem_wmask;
                rvfi_mem_rdata <= head.is_load ? head.mem_rdata : 32'h0;
                rvfi_mem_wdata <= head.mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ibex_rvfi_gen.sv
// Bench for ibex_rvfi_gen: directed literal scenarios, then randomized traffic against a queue model.
module tb_ibex_rvfi_gen;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_done_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] insn_i = '0, pc_i = '0, pc_next_i = '0;
    logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
    logic [31:0] rs1_rdata_i = '0, rs2_rdata_i = '0, rd_wdata_i = '0;
    logic        is_load_i = 1'b0;
    logic [31:0] mem_addr_i = '0, mem_wdata_i = '0, load_rdata_i = '0;
    logic [3:0]  mem_rmask_i = '0, mem_wmask_i = '0;
    logic        trap_i = 1'b0, halt_i = 1'b0, irq_taken_i = 1'b0;
    logic [1:0]  priv_mode_i = '0;
    logic        load_resp_valid_i = 1'b0, load_err_i = 1'b0;

    logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, proto_err_o;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [1:0]  rvfi_mode, rvfi_ixl;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    int n_checks = 0;
    int n_errors = 0;

    ibex_rvfi_gen #(.FifoDepth(DEPTH), .HartIxl(2'b01)) dut (
        .clk_i(clk), .rst_i(rst_i), .instr_done_i(instr_done_i), .instr_ready_o(instr_ready_o),
        .insn_i(insn_i), .pc_i(pc_i), .pc_next_i(pc_next_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i),
        .rd_addr_i(rd_addr_i), .rd_wdata_i(rd_wdata_i), .is_load_i(is_load_i),
        .mem_addr_i(mem_addr_i), .mem_rmask_i(mem_rmask_i), .mem_wmask_i(mem_wmask_i),
        .mem_wdata_i(mem_wdata_i), .trap_i(trap_i), .halt_i(halt_i),
        .priv_mode_i(priv_mode_i), .irq_taken_i(irq_taken_i),
        .load_resp_valid_i(load_resp_valid_i), .load_rdata_i(load_rdata_i), .load_err_i(load_err_i),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] insn, pc, pc_next, rs1_d, rs2_d, rd_d, maddr, mrdata, mwdata;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  rmask, wmask;
        logic [1:0]  mode;
        logic        trap, halt, intr, ld, done;
    } m_ent_t;

    m_ent_t      m_q[$];
    m_ent_t      e_out = '{default: '0};
    logic        e_valid = 1'b0;
    logic [63:0] e_order = '0;
    logic [63:0] m_order = '0;
    logic        m_iflag = 1'b0;
    logic        m_perr = 1'b0;

    function automatic int m_pend_idx();
        foreach (m_q[i]) if (m_q[i].ld && !m_q[i].done) return i;
        return -1;
    endfunction

    function automatic m_ent_t m_finish(m_ent_t e);
        m_ent_t r = e;
        r.done   = 1'b1;
        r.rd_d   = load_rdata_i;
        r.mrdata = load_rdata_i;
        if (load_err_i) begin
            r.trap = 1'b1;
            r.rd   = '0;
            r.rd_d = '0;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_q.delete();
            m_iflag = 1'b0; m_order = '0; m_perr = 1'b0;
            e_valid = 1'b0; e_order = '0; e_out = '{default: '0};
        end else begin : step
            int     pi;
            bit     rdy, enq, pop;
            m_ent_t n, h;
            rdy = (m_q.size() < DEPTH);
            pi  = m_pend_idx();
            pop = (m_q.size() > 0) && m_q[0].done;
            enq = instr_done_i && rdy;
            if (instr_done_i && !rdy) m_perr = 1'b1;
            if (enq && is_load_i && pi >= 0) begin m_perr = 1'b1; enq = 1'b0; end
            n = '{insn: insn_i, pc: pc_i, pc_next: pc_next_i, rs1_d: rs1_rdata_i, rs2_d: rs2_rdata_i,
                  rd_d: is_load_i ? 32'h0 : rd_wdata_i, maddr: mem_addr_i, mrdata: 32'h0,
                  mwdata: mem_wdata_i, rs1: rs1_addr_i, rs2: rs2_addr_i, rd: rd_addr_i,
                  rmask: mem_rmask_i, wmask: mem_wmask_i, mode: priv_mode_i, trap: trap_i,
                  halt: halt_i, intr: m_iflag | irq_taken_i, ld: is_load_i, done: !is_load_i};
            if (enq) m_iflag = 1'b0;
            else if (irq_taken_i) m_iflag = 1'b1;
            if (load_resp_valid_i) begin
                if (pi >= 0) m_q[pi] = m_finish(m_q[pi]);
                else if (enq && is_load_i) n = m_finish(n);
                else m_perr = 1'b1;
            end
            e_valid = pop;
            if (pop) begin
                h = m_q.pop_front();
                e_out = h;
                if (h.rd == 5'd0) e_out.rd_d = '0;
                e_order = m_order;
                m_order = m_order + 64'd1;
            end
            if (enq) m_q.push_back(n);
        end
    end

    // Compare process: every output, every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("instr_ready", instr_ready_o, m_q.size() < DEPTH);
        chk("proto_err", proto_err_o, m_perr);
        chk("valid", rvfi_valid, e_valid);
        chk("ixl", rvfi_ixl, 2'b01);
        chk("rs3", {rvfi_rs3_addr, rvfi_rs3_rdata}, 64'h0);
        chk("order", rvfi_order, e_order);
        chk("insn", rvfi_insn, e_out.insn);
        chk("flags", {rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode}, {e_out.trap, e_out.halt, e_out.intr, e_out.mode});
        chk("rs1", {rvfi_rs1_addr, rvfi_rs1_rdata}, {e_out.rs1, e_out.rs1_d});
        chk("rs2", {rvfi_rs2_addr, rvfi_rs2_rdata}, {e_out.rs2, e_out.rs2_d});
        chk("rd", {rvfi_rd_addr, rvfi_rd_wdata}, {e_out.rd, e_out.rd_d});
        chk("pc", {rvfi_pc_rdata, rvfi_pc_wdata}, {e_out.pc, e_out.pc_next});
        chk("mem_addr", rvfi_mem_addr, e_out.maddr);
        chk("mem_mask", {rvfi_mem_rmask, rvfi_mem_wmask}, {e_out.rmask, e_out.wmask});
        chk("mem_data", {rvfi_mem_rdata, rvfi_mem_wdata}, {e_out.mrdata, e_out.mwdata});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        instr_done_i = 0; is_load_i = 0; irq_taken_i = 0; load_resp_valid_i = 0; load_err_i = 0;
        trap_i = 0; halt_i = 0; mem_rmask_i = 0; mem_wmask_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic drive_op(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd, input logic ld);
        instr_done_i = 1'b1; is_load_i = ld;
        insn_i = 32'h0000_0013 ^ pc; pc_i = pc; pc_next_i = pc + 32'd4;
        rs1_addr_i = 5'd1; rs2_addr_i = 5'd2; rs1_rdata_i = 32'h11; rs2_rdata_i = 32'h22;
        rd_addr_i = rd; rd_wdata_i = wd; mem_addr_i = ld ? 32'h100 : 32'h0;
        mem_rmask_i = ld ? 4'hF : 4'h0;
    endtask

    int nvalid;
    logic [63:0] last_order;

    initial begin
        do_reset();
        chk("reset_valid", rvfi_valid, 1'b0);
        chk("reset_ready", instr_ready_o, 1'b1);
        chk("reset_ixl", rvfi_ixl, 2'b01);

        // Single ALU op: valid two cycles after the enqueue cycle.
        drive_op(32'h80, 5'd5, 32'h1234, 1'b0);
        tick(); clear_inputs();
        chk("alu_c1_valid", rvfi_valid, 1'b0);
        tick();
        chk("alu_c2_valid", rvfi_valid, 1'b1);
        chk("alu_order", rvfi_order, 64'd0);
        chk("alu_wdata", rvfi_rd_wdata, 32'h1234);
        chk("alu_pc_wdata", rvfi_pc_wdata, 32'h84);
        tick();
        chk("alu_c3_valid", rvfi_valid, 1'b0);

        // Load then ALU; ALU waits behind the load.
        do_reset();
        drive_op(32'h200, 5'd3, 32'h0, 1'b1);
        tick(); drive_op(32'h204, 5'd4, 32'h55, 1'b0);
        tick(); clear_inputs();
        chk("ld_full_c2", instr_ready_o, 1'b0);
        tick(); tick();
        load_resp_valid_i = 1'b1; load_rdata_i = 32'hCAFE;
        tick(); clear_inputs();
        chk("ld_c5_valid", rvfi_valid, 1'b0);
        tick();
        chk("ld_c6_valid", rvfi_valid, 1'b1);
        chk("ld_c6_order", rvfi_order, 64'd0);
        chk("ld_c6_wdata", rvfi_rd_wdata, 32'hCAFE);
        chk("ld_c6_ready", instr_ready_o, 1'b1);
        tick();
        chk("ld_c7_valid", rvfi_valid, 1'b1);
        chk("ld_c7_order", rvfi_order, 64'd1);
        chk("ld_c7_wdata", rvfi_rd_wdata, 32'h55);

        // Load bus error.
        do_reset();
        drive_op(32'h300, 5'd7, 32'h0, 1'b1); mem_rmask_i = 4'h3;
        tick(); clear_inputs();
        tick(); load_resp_valid_i = 1'b1; load_err_i = 1'b1; load_rdata_i = 32'hDEAD;
        tick(); clear_inputs();
        tick();
        chk("err_valid", rvfi_valid, 1'b1);
        chk("err_trap", rvfi_trap, 1'b1);
        chk("err_rd", {rvfi_rd_addr, rvfi_rd_wdata}, 64'h0);
        chk("err_rmask", rvfi_mem_rmask, 4'h3);

        // Interrupt flag attaches to the next enqueued instruction only.
        do_reset();
        tick(); tick(); tick();
        irq_taken_i = 1'b1;
        tick(); irq_taken_i = 1'b0;
        tick(); drive_op(32'h400, 5'd1, 32'h1, 1'b0);
        tick(); drive_op(32'h404, 5'd2, 32'h2, 1'b0);
        tick(); clear_inputs();
        chk("irq_a_valid", rvfi_valid, 1'b1);
        chk("irq_a_intr", rvfi_intr, 1'b1);
        tick();
        chk("irq_b_valid", rvfi_valid, 1'b1);
        chk("irq_b_intr", rvfi_intr, 1'b0);

        // 100 back-to-back ALU ops.
        do_reset();
        nvalid = 0; last_order = '1;
        for (int i = 0; i < 100; i++) begin
            drive_op(32'h1000 + 32'(i * 4), 5'(1 + i % 31), 32'(i), 1'b0);
            tick();
            chk("b2b_ready", instr_ready_o, 1'b1);
            if (rvfi_valid) begin nvalid++; last_order = rvfi_order; end
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rvfi_valid) begin nvalid++; last_order = rvfi_order; end
        end
        chk("b2b_count", 64'(nvalid), 64'd100);
        chk("b2b_last_order", last_order, 64'd99);

        // Reset mid-stream.
        for (int i = 0; i < 5; i++) begin
            drive_op(32'h2000 + 32'(i * 4), 5'd9, 32'(i), 1'b0);
            tick();
        end
        clear_inputs(); rst_i = 1'b1;
        tick();
        chk("mid_rst_valid", rvfi_valid, 1'b0);
        chk("mid_rst_order", rvfi_order, 64'd0);
        chk("mid_rst_insn", rvfi_insn, 32'h0);
        rst_i = 1'b0;
        drive_op(32'h3000, 5'd6, 32'h66, 1'b0);
        tick(); clear_inputs();
        tick();
        chk("post_rst_valid", rvfi_valid, 1'b1);
        chk("post_rst_order", rvfi_order, 64'd0);

        // Protocol errors are sticky until reset.
        do_reset();
        load_resp_valid_i = 1'b1; load_rdata_i = 32'h1;
        tick(); clear_inputs();
        chk("perr_resp", proto_err_o, 1'b1);
        tick(); tick(); tick();
        chk("perr_sticky", proto_err_o, 1'b1);
        do_reset();
        chk("perr_cleared", proto_err_o, 1'b0);
        drive_op(32'h500, 5'd1, 32'h0, 1'b1);
        tick(); drive_op(32'h504, 5'd2, 32'h0, 1'b1);
        tick(); clear_inputs();
        chk("perr_2load", proto_err_o, 1'b1);

        // Randomized traffic checked by the compare process.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit mrdy, mpend;
            mrdy  = (m_q.size() < DEPTH);
            mpend = (m_pend_idx() >= 0);
            rst_i             = ($urandom_range(0, 399) == 0);
            instr_done_i      = mrdy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 29) == 0);
            is_load_i         = mpend ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 9) < 3);
            insn_i            = $urandom; pc_i = $urandom; pc_next_i = $urandom;
            rs1_addr_i        = 5'($urandom); rs2_addr_i = 5'($urandom);
            rs1_rdata_i       = $urandom; rs2_rdata_i = $urandom;
            rd_addr_i         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rd_wdata_i        = $urandom;
            mem_addr_i        = $urandom; mem_wdata_i = $urandom;
            mem_rmask_i       = 4'($urandom); mem_wmask_i = 4'($urandom);
            trap_i            = ($urandom_range(0, 15) == 0);
            halt_i            = ($urandom_range(0, 15) == 0);
            priv_mode_i       = 2'($urandom);
            irq_taken_i       = ($urandom_range(0, 19) == 0);
            load_resp_valid_i = mpend ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
            load_rdata_i      = $urandom;
            load_err_i        = ($urandom_range(0, 9) == 0);
            tick();
        end
        clear_inputs();
        rst_i = 1'b0;
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
